// File: rtl/mdu_seq_pkg.sv
// Purpose: shared RV32M op encoding and fixed divide results for the MDU sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        MUL,
        MULH,
        MULHSU,
        MULHU,
        DIV,
        DIVU,
        REM,
        REMU
    } mdu_op_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    function automatic logic is_div_op(input mdu_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/mdu_step.sv
// Purpose: one radix-2 iteration; shift-add multiply or restoring-subtract divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_out.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;

    always_comb begin
        // Multiply: acc = {product_hi, remaining multiplier}; carry of the add lands in the top bit.
        sum    = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        // Divide: acc = {rem, quot}; shifted remainder needs one extra bit before the compare.
        rem_sh = acc_in[2*XLEN-1:XLEN-1];
        diff   = rem_sh[XLEN-1:0] - operand;
        if (is_div) begin
            if (rem_sh >= {1'b0, operand}) begin
                acc_out = {diff, acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {acc_in[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Purpose: multi-cycle RV32M multiply/divide beside the E-stage ALU; MDU_EARLY_OUT_EN adds multiply early-out.
// Latency: XLEN+1 cycles start-to-done (1 cycle for divide-by-zero/overflow, fewer with early-out).
// Backpressure: stall_out holds F/D/E from start acceptance until done_out; flush_in aborts with no done.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int CNT_BITS = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_in,
    input  logic            start_in,
    input  mdu_op_e         op_in,
    input  logic [XLEN-1:0] src1_in,
    input  logic [XLEN-1:0] src2_in,
    output logic            stall_out,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;

    mdu_state_e          state_q, state_d;
    mdu_op_e             op_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opnd_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                neg_q;
    logic [XLEN-1:0]     result_q;

    logic                s1_neg, s2_neg, start_neg;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     fast_res;
    logic [2*XLEN-1:0]   step_acc, final_acc, prod;
    logic [XLEN-1:0]     quot, rem, fixed_res;
    logic                early, finish_cond;
    logic                go_slow, go_fast, step_en, finish;

    // Start-time operand conditioning: magnitudes plus the sign to reapply at the end.
    always_comb begin
        s1_neg    = src1_in[XLEN-1] & (op_in inside {MULH, MULHSU, DIV, REM});
        s2_neg    = src2_in[XLEN-1] & (op_in inside {MULH, DIV, REM});
        mag1      = s1_neg ? -src1_in : src1_in;
        mag2      = s2_neg ? -src2_in : src2_in;
        start_neg = (op_in == REM) ? s1_neg : (s1_neg ^ s2_neg);
        div_zero  = is_div_op(op_in) && (src2_in == '0);
        div_ovf   = (op_in inside {DIV, REM}) && (src1_in == INT_MIN) && (src2_in == '1);
        if (div_zero) begin
            fast_res = (op_in inside {DIV, DIVU}) ? DIV_BY_ZERO_Q : src1_in;
        end else begin
            fast_res = (op_in == DIV) ? INT_MIN : '0;
        end
    end

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div_op(op_q)),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (step_acc)
    );

`ifdef MDU_EARLY_OUT_EN
    logic [CNT_BITS-1:0] rem_cnt;
    logic [XLEN-1:0]     mlt_mask;

    // Low rem_cnt bits of the accumulator still hold unconsumed multiplier bits.
    always_comb begin
        rem_cnt  = cnt_q - CNT_BITS'(1);
        mlt_mask = ~({XLEN{1'b1}} << rem_cnt);
        early    = !is_div_op(op_q) && ((step_acc[XLEN-1:0] & mlt_mask) == '0);
        final_acc = is_div_op(op_q) ? step_acc : (step_acc >> rem_cnt);
    end
`else
    assign early     = 1'b0;
    assign final_acc = step_acc;
`endif

    assign finish_cond = (cnt_q == CNT_BITS'(1)) || early;

    always_comb begin
        prod = neg_q ? -final_acc : final_acc;
        quot = final_acc[XLEN-1:0];
        rem  = final_acc[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                 fixed_res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: fixed_res = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           fixed_res = neg_q ? -quot : quot;
            default:             fixed_res = neg_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        go_slow = 1'b0;
        go_fast = 1'b0;
        step_en = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (div_zero || div_ovf) begin
                        go_fast = 1'b1;
                        state_d = DONE;
                    end else begin
                        go_slow = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                step_en = 1'b1;
                if (finish_cond) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_in) begin
            state_d = IDLE;
            go_slow = 1'b0;
            go_fast = 1'b0;
            step_en = 1'b0;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (go_slow) begin
                op_q   <= op_in;
                // Divide: acc = {0, dividend}; multiply: acc = {0, multiplier}.
                acc_q  <= is_div_op(op_in) ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
                opnd_q <= is_div_op(op_in) ? mag2 : mag1;
                neg_q  <= start_neg;
                cnt_q  <= CNT_BITS'(XLEN);
            end
            if (go_fast) begin
                result_q <= fast_res;
            end
            if (step_en) begin
                acc_q <= step_acc;
                cnt_q <= cnt_q - CNT_BITS'(1);
            end
            if (finish) begin
                result_q <= fixed_res;
            end
        end
    end

    assign stall_out  = ((state_q == IDLE) && start_in && !flush_in) || ((state_q == BUSY) && !flush_in);
    assign busy_out   = (state_q != IDLE);
    assign done_out   = (state_q == DONE) && !flush_in;
    assign result_out = result_q;

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer beside the execute-stage ALU. It handles the RV32M ops that the single-cycle ALU cannot.
- It accepts an op from the E stage and holds the pipeline via stall_out while running radix-2 iterations: shift-add for multiply, restoring subtraction for divide.
- It delivers the result for one cycle so the E stage passes it to the C-stage register in place of the ALU result.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_BITS, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- flush_in  in  1  E-stage flush; aborts any operation in flight.
- start_in  in  1  E stage holds a valid MDU op; held high until done_out.
- op_in  in  mdu_op_e  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- src1_in  in  XLEN  forwarded rs1 value.
- src2_in  in  XLEN  forwarded rs2 value.
- stall_out  out  1  hold F/D/E pipeline registers.
- busy_out  out  1  state != IDLE.
- done_out  out  1  one-cycle pulse; result_out valid.
- result_out  out  XLEN  operation result.

Behaviour:
- Reset (reset=0, async): state=IDLE; counter, accumulator, operand and result registers =0; done_out=0; stall_out=0; busy_out=0.
- stall_out = (state==IDLE & start_in & ~flush_in) | state==BUSY. It is combinational and low in DONE.
- IDLE, start_in=1, normal case:
  - latch op_in;
  - latch operand magnitudes (signed ops take |x|; MULHSU takes only src1 as signed);
  - latch the result sign: product sign = s1^s2; quotient sign = s1^s2; remainder sign = sign of src1;
  - counter=XLEN; go to BUSY.
- IDLE fast path, straight to DONE with these results:
  - divisor==0: DIV/DIVU result all ones; REM/REMU result = src1.
  - DIV with src1=0x80000000, src2=0xFFFFFFFF: result 0x80000000; REM gives 0.
- BUSY, one iteration per cycle:
  - Multiply: if multiplier[0], add the multiplicand into the upper half of the 2*XLEN accumulator; then shift right by 1.
  - Divide: shift {rem,quot} left by 1; if rem>=divisor, subtract and set quot[0].
  - Decrement the counter. When the counter reaches 1, next state is DONE and the sign-fixed result (two's complement negate if sign set) is registered into result_out.
- Result selection: MUL takes the low half; MULH/MULHSU/MULHU take the high half of the sign-fixed 2*XLEN product. DIV*/REM* take quotient or remainder.
- DONE: done_out=1 for exactly one cycle, stall_out=0, then IDLE unconditionally. start_in still high in DONE does not restart; a new op starts only from IDLE.
- Latency, normal path: start seen in cycle 0, BUSY in cycles 1..XLEN, DONE in cycle XLEN+1. Stall is held for XLEN+1 cycles. Fast path: DONE in cycle 1.
- result_out holds its value after DONE until the next op completes.
- flush_in=1 in any state: next state IDLE, no done_out, stall_out=0 that cycle. flush_in has priority over start_in.
- Operands are captured once at start; src changes during BUSY are ignored.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: for multiply ops in BUSY, when the remaining multiplier register is 0, skip to DONE next cycle. Before skipping, shift the accumulator right by the remaining count so the result equals the full-iteration result.
  - Example: MUL 7*3 finishes with DONE in cycle 3.
- Undefined: multiply always takes XLEN BUSY cycles.
- Divide is unaffected either way.

Decomposition:
- Shared package gets mdu_op_e (3-bit enum, order as listed) and the result constants DIV_BY_ZERO_Q (all ones) and INT_MIN (0x80000000).
- Local to the module: mdu_state_e {IDLE, BUSY, DONE}.
- One sub-module, mdu_step: a combinational single iteration (shift-add or restore-subtract) taking op class, accumulator and operand, and returning the next accumulator.

Test Plan:
- MUL 0x00000007 * 0xFFFFFFFD (-3) → result 0xFFFFFFEB; stall high for 33 cycles; done_out pulse in cycle 33.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU same operands → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, done in cycle 1. DIV 0x80000000 / -1 → 0x80000000, done in cycle 1.
- flush_in asserted in BUSY cycle 10 → IDLE next cycle, no done_out, stall_out low. A following MUL 6*7 → 42.
- reset driven low mid-BUSY (asynchronous) → IDLE immediately, all outputs 0. With MDU_EARLY_OUT_EN defined, MUL 7*3 → 21 with done in cycle 3.
